// File: rtl/axi_burst_pkg.sv
// Shared constants and FSM state types for the AXI burst slave.
// Burst encodings, response codes, write/read FSM enums.
package axi_burst_pkg;

  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address and legality for one burst channel.
// In: addr, len, burst. Out: next, legal. WRAP under AXI_BURST_SLAVE_WRAP_EN.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next,
  output logic              legal
);

  logic [ADDR_W-1:0] inc;
  assign inc = addr + ADDR_W'(1);

`ifdef AXI_BURST_SLAVE_WRAP_EN
  logic [ADDR_W-1:0] mask;
  logic              len_ok;
  // LEN+1 is a power of two, so LEN itself is the in-block offset mask
  assign mask   = ADDR_W'(len);
  assign len_ok = (len == LEN_W'(1)) ||
                  (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) ||
                  (len == LEN_W'(15));
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  always_comb begin
    next  = addr;
    legal = 1'b0;
    case (burst)
      FIXED: legal = 1'b1;
      INCR: begin
        next  = inc;
        legal = 1'b1;
      end
`ifdef AXI_BURST_SLAVE_WRAP_EN
      WRAP: begin
        next  = (addr & ~mask) | (inc & mask);
        legal = len_ok;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_burst_slave.sv
// AXI-style burst slave: word memory, independent AW/W/B and AR/R channels.
// Ports: clk, rst (async low), AW*, W*, B*, AR*, R*. Macro: AXI_BURST_SLAVE_WRAP_EN.
module axi_burst_slave
  import axi_burst_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [ID_W-1:0]   AWID,
  input  logic [1:0]        AWBURST,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic [ID_W-1:0]   BID,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [ID_W-1:0]   ARID,
  input  logic [1:0]        ARBURST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic [ID_W-1:0]   RID
);

  localparam int IDX_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_t          w_state, w_state_n;
  logic [ADDR_W-1:0] w_addr, w_next;
  logic [LEN_W-1:0]  w_len, w_beat;
  logic [ID_W-1:0]   w_id;
  logic [1:0]        w_burst;
  logic              w_err, w_legal;
  logic              w_ok, w_hs, w_end;

  r_state_t          r_state, r_state_n;
  logic [ADDR_W-1:0] r_addr, r_next;
  logic [LEN_W-1:0]  r_len, r_beat;
  logic [ID_W-1:0]   r_id;
  logic [1:0]        r_burst;
  logic              r_legal, r_ok, r_end;

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_w_gen (
    .addr (w_addr),
    .len  (w_len),
    .burst(w_burst),
    .next (w_next),
    .legal(w_legal)
  );

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_r_gen (
    .addr (r_addr),
    .len  (r_len),
    .burst(r_burst),
    .next (r_next),
    .legal(r_legal)
  );

  assign w_ok  = w_legal &&
                 ({1'b0, w_addr} < DEPTH_C);
  assign w_end = (w_beat == w_len);
  assign w_hs  = WVALID && WREADY;

  assign r_ok  = r_legal &&
                 ({1'b0, r_addr} < DEPTH_C);
  assign r_end = (r_beat == r_len);

  always_comb begin
    w_state_n = w_state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = OKAY;
    BID       = '0;
    unique case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_n = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_end) w_state_n = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = w_err ? SLVERR : OKAY;
        BID    = w_id;
        if (BREADY) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_id    <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_n;
      if (AWVALID && AWREADY) begin
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_id    <= AWID;
        w_burst <= AWBURST;
        w_beat  <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_next;
        w_beat <= w_beat + LEN_W'(1);
        // Early or missing WLAST still ends on beat LEN
        if (!w_ok || (WLAST != w_end))
          w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_ok)
      mem[w_addr[IDX_W-1:0]] <= WDATA;
  end

  always_comb begin
    r_state_n = r_state;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RDATA     = '0;
    RRESP     = OKAY;
    RLAST     = 1'b0;
    RID       = '0;
    unique case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_n = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        // Combinational read: a same-cycle write lands after this beat
        if (r_ok)
          RDATA = mem[r_addr[IDX_W-1:0]];
        RRESP = r_ok ? OKAY : SLVERR;
        RLAST = r_end;
        RID   = r_id;
        if (RREADY && r_end) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_id    <= '0;
      r_burst <= '0;
    end else begin
      r_state <= r_state_n;
      if (ARVALID && ARREADY) begin
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_id    <= ARID;
        r_burst <= ARBURST;
        r_beat  <= '0;
      end
      if (RVALID && RREADY) begin
        r_addr <= r_next;
        r_beat <= r_beat + LEN_W'(1);
      end
    end
  end

endmodule
